bpred_update_arbiter: RTL

//  - Shares one single-port branch-target/2-bit-counter table between fetch-stage lookups and decode-stage resolve updates.
//  - Resolve updates are buffered in a small FIFO and written back opportunistically in cycles with no lookup.
//  - When the FIFO crosses its high watermark, the write is forced and fetch is stalled for that cycle.
//  - Sits between fetch PC logic (consumes prediction and stall) and the branch resolve logic in decode.

---
 rtl/bpred_update_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bpred_update_arbiter.sv
// bpred_update_arbiter: single-port branch predictor table shared by fetch lookups and buffered resolve updates.
// Optional BPRED_BYPASS_EN lets lookups see pending FIFO updates (newest match wins).
module bpred_update_arbiter #(
    parameter int ENTRIES    = 16,
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int HI_WATER   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lookup_req_f,
    input  logic [31:0]                   lookup_pc_f,
    output logic                          pred_hit_f,
    output logic                          pred_taken_f,
    output logic [31:0]                   pred_target_f,
    output logic                          stall_f,
    input  logic                          upd_valid_d,
    output logic                          upd_ready_d,
    input  logic [31:0]                   upd_pc_d,
    input  logic [31:0]                   upd_target_d,
    input  logic                          upd_taken_d,
    output logic [$clog2(FIFO_DEPTH):0]   pend_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [PTR_W:0] HI_CNT   = HI_WATER[PTR_W:0];
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [TAG_W-1:0]      tag_d [ENTRIES];
    logic [31:0]           tgt_q [ENTRIES];
    logic [31:0]           tgt_d [ENTRIES];
    logic [1:0]            ctr_q [ENTRIES];
    logic [1:0]            ctr_d [ENTRIES];
    logic [31:2]           fpc_q [FIFO_DEPTH];
    logic [31:2]           fpc_d [FIFO_DEPTH];
    logic [31:0]           ftgt_q [FIFO_DEPTH];
    logic [31:0]           ftgt_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ftk_q, ftk_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]        cnt_q, cnt_d;

    logic              force_wr, wr, push, hit, tk, h_hit, h_tk, unused_pc_bits;
    logic [31:0]       tgt;
    logic [IDX_W-1:0]  lk_idx, h_idx;
    logic [31:2]       h_pc;
    logic [PTR_W-1:0]  b_idx;

    assign unused_pc_bits = ^{lookup_pc_f[1:0], upd_pc_d[1:0]};

    always_comb begin
        force_wr    = cnt_q >= HI_CNT;
        wr          = force_wr || (cnt_q != '0 && !lookup_req_f);
        upd_ready_d = cnt_q != FULL_CNT;
        push        = upd_valid_d && upd_ready_d;
        stall_f     = force_wr;
        pend_cnt    = cnt_q;
        lk_idx      = lookup_pc_f[IDX_W+1:2];
        hit         = valid_q[lk_idx] && tag_q[lk_idx] == lookup_pc_f[31:IDX_W+2];
        tk          = hit && ctr_q[lk_idx][1];
        tgt         = hit ? tgt_q[lk_idx] : 32'd0;
        b_idx       = '0;
`ifdef BPRED_BYPASS_EN
        // walk oldest to newest so the youngest matching update overrides
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            b_idx = head_q + PTR_W'(i);
            if ((PTR_W+1)'(i) < cnt_q && fpc_q[b_idx] == lookup_pc_f[31:2]) begin
                hit = 1'b1;
                tk  = ftk_q[b_idx];
                tgt = ftk_q[b_idx] ? ftgt_q[b_idx] : tgt;
            end
        end
`endif
        pred_hit_f    = lookup_req_f && !force_wr && hit;
        pred_taken_f  = lookup_req_f && !force_wr && tk;
        pred_target_f = (lookup_req_f && !force_wr) ? tgt : 32'd0;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        fpc_d   = fpc_q;
        ftgt_d  = ftgt_q;
        ftk_d   = ftk_q;
        h_pc    = fpc_q[head_q];
        h_tk    = ftk_q[head_q];
        h_idx   = h_pc[IDX_W+1:2];
        h_hit   = valid_q[h_idx] && tag_q[h_idx] == h_pc[31:IDX_W+2];
        if (wr && h_hit) begin
            ctr_d[h_idx] = h_tk ? (ctr_q[h_idx] == 2'b11 ? 2'b11 : ctr_q[h_idx] + 2'd1)
                                : (ctr_q[h_idx] == 2'b00 ? 2'b00 : ctr_q[h_idx] - 2'd1);
            tgt_d[h_idx] = h_tk ? ftgt_q[head_q] : tgt_q[h_idx];
        end else if (wr && h_tk) begin
            valid_d[h_idx] = 1'b1;
            tag_d[h_idx]   = h_pc[31:IDX_W+2];
            tgt_d[h_idx]   = ftgt_q[head_q];
            ctr_d[h_idx]   = 2'b10;
        end
        if (push) begin
            fpc_d[tail_q]  = upd_pc_d[31:2];
            ftgt_d[tail_q] = upd_target_d;
            ftk_d[tail_q]  = upd_taken_d;
        end
        head_d = head_q + PTR_W'(wr);
        tail_d = tail_q + PTR_W'(push);
        cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fpc_q[i]  <= '0;
                ftgt_q[i] <= '0;
            end
            ftk_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
            fpc_q   <= fpc_d;
            ftgt_q  <= ftgt_d;
            ftk_q   <= ftk_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
